brick_grid_sequencer: RTL and testbench
=======================================

// Module: brick_grid_sequencer
// PURPOSE
//  Initiator for the brick sprite drawer: walks the brick map RAM, drives the drawer's reset/enable/select
//  handshake per cell, waits for its end flag, and re-times drawer pixels into a VGA plot stream.
//  Sits between game logic (level load, brick-hit redraw) and the brick drawer / VGA adapter write port.
// PARAMETERS
//  COLS     10   bricks per row
//  ROWS      6   brick rows; map depth = COLS*ROWS
//  X0        8   8-bit x of top-left brick
//  Y0       16   8-bit y of top-left brick
//  PITCH_X  12   x step between columns (brick width 12 + gap)
//  PITCH_Y   6   y step between rows (brick height 6 + gap)
//  AW        6   map address width, >= clog2(COLS*ROWS)
// PORTS
//  clk             in   1   system clock
//  reset           in   1   synchronous, active-high
//  start           in   1   1-cycle pulse: draw whole grid
//  cell_req        in   1   1-cycle pulse: redraw one cell
//  cell_col        in   8   column for cell_req
//  cell_row        in   8   row for cell_req
//  busy            out  1   high from accepted request until done
//  done            out  1   1-cycle pulse after last pixel plotted
//  map_addr        out  AW  brick map read address (row*COLS+col)
//  map_data        in   3   brick type; 1-cycle synchronous read latency
//  brickDrawReset  out  1   drawer counter clear
//  brickDrawEnable out  1   drawer counter run
//  brickDrawSelect out  3   brick type, held stable for whole cell
//  brickDrawEnd    in   1   drawer finished (registered, sticky until reset)
//  x, y            out  8   drawer origin (cell top-left)
//  x_draw, y_draw  in   8   drawer pixel coordinate (combinational from its counter)
//  colour_in       in   24  drawer colour (valid 1 cycle after x_draw/y_draw)
//  vga_x, vga_y    out  8   registered x_draw/y_draw, aligned with colour
//  vga_colour      out  24  colour_in passed through
//  vga_plot        out  1   pixel write strobe
// BEHAVIOUR
//  Reset: state IDLE; busy, done, vga_plot, brickDrawEnable, brickDrawReset = 0; map_addr, x, y,
//   vga_x, vga_y, brickDrawSelect = 0. Reset mid-draw aborts immediately; no done pulse.
//  FSM: IDLE -> FETCH -> WAIT_MAP -> CLEAR -> DRAW -> (NEXT -> FETCH | FINISH) -> IDLE.
//   IDLE: start accepted -> col=row=0, addr=0, x=X0, y=Y0, full mode. Else cell_req with col<COLS and
//    row<ROWS -> single mode at that cell (x=X0+col*PITCH_X etc., computed once). Out-of-range cell_req
//    ignored. start and cell_req same cycle: start wins. Requests while busy dropped (not queued).
//   FETCH: map_addr driven (1 cycle). WAIT_MAP: latch map_data into brickDrawSelect.
//   CLEAR: brickDrawReset=1, enable=0, one cycle. DRAW: enable=1 until brickDrawEnd sampled 1.
//   NEXT (full mode): col+1; at col==COLS-1 wrap col=0, row+1, x=X0, y+=PITCH_Y; else x+=PITCH_X;
//    addr+1. After row ROWS-1, col COLS-1 -> FINISH. Single mode: DRAW -> FINISH.
//   FINISH: wait until vga_plot pipeline empty, pulse done, busy=0 next cycle.
//  Type 0 (NOBRICK) cells still drawn (drawer emits background, erases hit bricks).
//  Pixel alignment: vga_x/vga_y <= x_draw/y_draw each cycle; vga_plot <= (state==DRAW && !brickDrawEnd).
//   Latency 1 cycle; exactly 72 plots per cell (12x6 sprite); no plot during CLEAR/FETCH.
//  Arithmetic: x/y 8-bit, incremental add, wrap mod 256 (no saturation); no multipliers in full mode.
// STRUCTURE
//  brick_pkg: brick type codes (NOBRICK=0, RED=1, BROWN=2, SRED=3, SBROWN=4), sprite size 12x6,
//   default grid geometry, FSM state enum.
//  Sub-module grid_cursor: col/row/addr/x/y incremental counters with load (full/cell) and step inputs.
// TESTING
//  Bench models drawer exactly (counter 0..11 x 0..5, registered end, 1-cycle colour RAM) and map RAM.
//  1 start, map all RED -> 60 cells, 4320 vga_plot pulses, done once, busy high throughout.
//  2 start, first cell plots -> vga_x 8..19, vga_y 16..21; cell(1,0) begins x=20; row 1 begins y=22.
//  3 cell_req col=3,row=2 type SBROWN -> map_addr=23, select=4 held, 72 plots at x 44..55, y 28..33.
//  4 start+cell_req same cycle -> full grid; cell_req mid-draw -> ignored, plot count unchanged.
//  5 reset asserted mid-DRAW -> next cycle all outputs 0, IDLE; new start completes normally.
//  6 cell_req col=10 (COLS=10) -> busy stays 0, no map read, no plots.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared definitions for the brick grid sequencer slice.
// Holds the brick type codes understood by the sprite drawer, the sprite
// footprint, the default grid geometry and the sequencer state encoding.
package brick_pkg;

    // Brick type codes as stored in the brick map RAM
    typedef enum logic [2:0] {
        NOBRICK = 3'd0,
        RED     = 3'd1,
        BROWN   = 3'd2,
        SRED    = 3'd3,
        SBROWN  = 3'd4
    } brick_type_e;

    // Sprite footprint produced by the drawer for one cell
    localparam int SPRITE_W = 12;
    localparam int SPRITE_H = 6;

    // Default grid geometry
    localparam int DEF_COLS    = 10;
    localparam int DEF_ROWS    = 6;
    localparam int DEF_X0      = 8;
    localparam int DEF_Y0      = 16;
    localparam int DEF_PITCH_X = 12;
    localparam int DEF_PITCH_Y = 6;
    localparam int DEF_AW      = 6;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_MAP = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_DRAW     = 3'd4,
        ST_NEXT     = 3'd5,
        ST_FINISH   = 3'd6
    } seq_state_e;

endpackage

// File: rtl/brick_grid_sequencer_cursor.sv
// grid_cursor: column/row/map-address/pixel-origin tracker for the sequencer.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   load_full             point at cell (0,0) for a whole-grid pass
//   load_cell             point at (cell_col, cell_row) for a single redraw
//   step                  advance one cell in raster order
//   cell_col, cell_row    target cell for load_cell
//   addr                  map address row*COLS+col
//   x, y                  top-left pixel of the current cell
//   last                  current cell is the bottom-right one
module grid_cursor
    import brick_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int X0      = DEF_X0,
    parameter int Y0      = DEF_Y0,
    parameter int PITCH_X = DEF_PITCH_X,
    parameter int PITCH_Y = DEF_PITCH_Y,
    parameter int AW      = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_full,
    input  logic          load_cell,
    input  logic          step,
    input  logic [7:0]    cell_col,
    input  logic [7:0]    cell_row,
    output logic [AW-1:0] addr,
    output logic [7:0]    x,
    output logic [7:0]    y,
    output logic          last
);

    localparam logic [7:0] LAST_COL = 8'(COLS - 1);
    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

    logic [7:0]    col_q, col_d;
    logic [7:0]    row_q, row_d;
    logic [7:0]    x_q, x_d;
    logic [7:0]    y_q, y_d;
    logic [AW-1:0] addr_q, addr_d;

    // A single-cell load computes its origin with a multiply once; the
    // whole-grid walk only ever adds pitches, wrapping modulo 256.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (load_full) begin
            col_d  = 8'd0;
            row_d  = 8'd0;
            x_d    = 8'(X0);
            y_d    = 8'(Y0);
            addr_d = '0;
        end else if (load_cell) begin
            col_d  = cell_col;
            row_d  = cell_row;
            x_d    = 8'(X0 + int'(cell_col) * PITCH_X);
            y_d    = 8'(Y0 + int'(cell_row) * PITCH_Y);
            addr_d = AW'(int'(cell_row) * COLS + int'(cell_col));
        end else if (step) begin
            addr_d = addr_q + AW'(1);
            if (col_q == LAST_COL) begin
                col_d = 8'd0;
                row_d = row_q + 8'd1;
                x_d   = 8'(X0);
                y_d   = y_q + 8'(PITCH_Y);
            end else begin
                col_d = col_q + 8'd1;
                x_d   = x_q + 8'(PITCH_X);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q  <= 8'd0;
            row_q  <= 8'd0;
            x_q    <= 8'd0;
            y_q    <= 8'd0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    assign x    = x_q;
    assign y    = y_q;
    assign last = (col_q == LAST_COL) && (row_q == LAST_ROW);

endmodule

// File: rtl/brick_grid_sequencer.sv
// brick_grid_sequencer: walks the brick map, runs the sprite drawer one cell
// at a time and re-times its pixels into a VGA plot stream.
// Ports:
//   clk, reset                clock, synchronous active-high reset
//   start                     pulse: draw the whole grid
//   cell_req/cell_col/cell_row pulse: redraw a single cell
//   busy, done                request in progress / one-cycle completion pulse
//   map_addr, map_data        brick map read port (1-cycle read latency)
//   brickDrawReset/Enable     drawer counter clear / run
//   brickDrawSelect           brick type for the current cell
//   brickDrawEnd              drawer finished (sticky until cleared)
//   x, y                      drawer origin for the current cell
//   x_draw, y_draw, colour_in drawer pixel coordinate and its colour
//   vga_x, vga_y, vga_colour, vga_plot  VGA adapter write port
module brick_grid_sequencer
    import brick_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int X0      = DEF_X0,
    parameter int Y0      = DEF_Y0,
    parameter int PITCH_X = DEF_PITCH_X,
    parameter int PITCH_Y = DEF_PITCH_Y,
    parameter int AW      = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          cell_req,
    input  logic [7:0]    cell_col,
    input  logic [7:0]    cell_row,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] map_addr,
    input  logic [2:0]    map_data,
    output logic          brickDrawReset,
    output logic          brickDrawEnable,
    output logic [2:0]    brickDrawSelect,
    input  logic          brickDrawEnd,
    output logic [7:0]    x,
    output logic [7:0]    y,
    input  logic [7:0]    x_draw,
    input  logic [7:0]    y_draw,
    input  logic [23:0]   colour_in,
    output logic [7:0]    vga_x,
    output logic [7:0]    vga_y,
    output logic [23:0]   vga_colour,
    output logic          vga_plot
);

    localparam logic [7:0] COLS_8 = 8'(COLS);
    localparam logic [7:0] ROWS_8 = 8'(ROWS);

    seq_state_e state_q, state_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       full_q, full_d;
    logic [2:0] select_q, select_d;
    logic       plot_q, plot_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [7:0] vga_y_q, vga_y_d;

    logic load_full, load_cell, step, last_cell;
    logic draw_reset, draw_enable;
    logic cell_ok;

    grid_cursor #(
        .COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0),
        .PITCH_X(PITCH_X), .PITCH_Y(PITCH_Y), .AW(AW)
    ) u_cursor (
        .clk      (clk),
        .reset    (reset),
        .load_full(load_full),
        .load_cell(load_cell),
        .step     (step),
        .cell_col (cell_col),
        .cell_row (cell_row),
        .addr     (map_addr),
        .x        (x),
        .y        (y),
        .last     (last_cell)
    );

    assign cell_ok = (cell_col < COLS_8) && (cell_row < ROWS_8);

    // Sequencer next-state and drawer handshake. Requests are only looked at
    // in IDLE, so anything arriving while busy is simply dropped.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        full_d      = full_q;
        select_d    = select_q;
        load_full   = 1'b0;
        load_cell   = 1'b0;
        step        = 1'b0;
        draw_reset  = 1'b0;
        draw_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_full = 1'b1;
                    full_d    = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_FETCH;
                end else if (cell_req && cell_ok) begin
                    load_cell = 1'b1;
                    full_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH:    state_d = ST_WAIT_MAP;
            ST_WAIT_MAP: begin
                select_d = map_data;
                state_d  = ST_CLEAR;
            end
            ST_CLEAR: begin
                draw_reset = 1'b1;
                state_d    = ST_DRAW;
            end
            ST_DRAW: begin
                draw_enable = 1'b1;
                if (brickDrawEnd) begin
                    state_d = (full_q && !last_cell) ? ST_NEXT : ST_FINISH;
                end
            end
            ST_NEXT: begin
                step    = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FINISH: begin
                // Hold off completion until the last re-timed pixel is out
                if (!plot_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pixel re-timing: coordinates are delayed one cycle so they line up with
    // the drawer's registered colour; the end cycle itself is not plotted.
    always_comb begin
        vga_x_d = x_draw;
        vga_y_d = y_draw;
        plot_d  = (state_q == ST_DRAW) && !brickDrawEnd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            full_q   <= 1'b0;
            select_q <= 3'd0;
            plot_q   <= 1'b0;
            vga_x_q  <= 8'd0;
            vga_y_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            full_q   <= full_d;
            select_q <= select_d;
            plot_q   <= plot_d;
            vga_x_q  <= vga_x_d;
            vga_y_q  <= vga_y_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign brickDrawReset  = draw_reset;
    assign brickDrawEnable = draw_enable;
    assign brickDrawSelect = select_q;
    assign vga_x           = vga_x_q;
    assign vga_y           = vga_y_q;
    assign vga_colour      = colour_in;
    assign vga_plot        = plot_q;

endmodule

// File: tb/tb_brick_grid_sequencer.sv
// Directed testbench for brick_grid_sequencer with a cycle-exact model of the
// brick sprite drawer and the synchronous brick map RAM.
module tb_brick_grid_sequencer;
    import brick_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, cell_req;
    logic [7:0]  cell_col, cell_row;
    logic        busy, done;
    logic [5:0]  map_addr;
    logic [2:0]  map_data;
    logic        brickDrawReset, brickDrawEnable, brickDrawEnd;
    logic [2:0]  brickDrawSelect;
    logic [7:0]  x, y, x_draw, y_draw, vga_x, vga_y;
    logic [23:0] colour_in, vga_colour;
    logic        vga_plot;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    brick_grid_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cell_req       (cell_req),
        .cell_col       (cell_col),
        .cell_row       (cell_row),
        .busy           (busy),
        .done           (done),
        .map_addr       (map_addr),
        .map_data       (map_data),
        .brickDrawReset (brickDrawReset),
        .brickDrawEnable(brickDrawEnable),
        .brickDrawSelect(brickDrawSelect),
        .brickDrawEnd   (brickDrawEnd),
        .x              (x),
        .y              (y),
        .x_draw         (x_draw),
        .y_draw         (y_draw),
        .colour_in      (colour_in),
        .vga_x          (vga_x),
        .vga_y          (vga_y),
        .vga_colour     (vga_colour),
        .vga_plot       (vga_plot)
    );

    // Brick map RAM with one cycle of read latency
    logic [2:0] mem [0:63];
    always @(posedge clk) map_data <= mem[map_addr];

    // Drawer model: 12x6 raster counter, registered sticky end, colour one
    // cycle behind the coordinate (encodes type and coordinate for checking)
    logic [7:0] cx, cy;
    logic       dend;
    always @(posedge clk) begin
        if (reset || brickDrawReset) begin
            cx   <= 8'd0;
            cy   <= 8'd0;
            dend <= 1'b0;
        end else if (brickDrawEnable && !dend) begin
            if (cx == 8'd11) begin
                cx <= 8'd0;
                if (cy == 8'd5) dend <= 1'b1;
                else cy <= cy + 8'd1;
            end else begin
                cx <= cx + 8'd1;
            end
        end
        colour_in <= {brickDrawSelect, 5'd0, x_draw, y_draw};
    end
    assign brickDrawEnd = dend;
    assign x_draw = x + cx;
    assign y_draw = y + cy;

    // Output monitor sampled on the falling edge
    logic [7:0] px [0:16383];
    logic [7:0] py [0:16383];
    int plot_count = 0;
    int done_count = 0;
    int clear_count = 0;
    int colour_err = 0;
    always @(negedge clk) begin
        if (vga_plot) begin
            if (plot_count < 16384) begin
                px[plot_count] = vga_x;
                py[plot_count] = vga_y;
            end
            if (vga_colour !== {brickDrawSelect, 5'd0, vga_x, vga_y}) colour_err++;
            plot_count++;
        end
        if (done) done_count++;
        if (brickDrawReset) clear_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic c,
                                 input logic [7:0] col, input logic [7:0] row);
        @(negedge clk);
        start    = s;
        cell_req = c;
        cell_col = col;
        cell_row = row;
        @(negedge clk);
        start    = 1'b0;
        cell_req = 1'b0;
    endtask

    task automatic runUntilDone(input int budget, output int busy_low, output bit timed_out);
        busy_low  = 0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (!busy) busy_low++;
        end
    endtask

    int  base, busy_low, pc0, dc0, cc0;
    bit  timed_out;

    initial begin
        reset = 1'b1; start = 1'b0; cell_req = 1'b0; cell_col = 8'd0; cell_row = 8'd0;
        for (int i = 0; i < 64; i++) mem[i] = RED;
        repeat (3) @(negedge clk);

        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_plot", 32'(vga_plot), 32'd0);
        checkOutput("rst_enable", 32'(brickDrawEnable), 32'd0);
        checkOutput("rst_clear", 32'(brickDrawReset), 32'd0);
        checkOutput("rst_addr", 32'(map_addr), 32'd0);
        checkOutput("rst_x", 32'(x), 32'd0);
        checkOutput("rst_select", 32'(brickDrawSelect), 32'd0);
        reset = 1'b0;

        // Full grid, every cell RED
        $display("[TB] full grid draw");
        base = plot_count; dc0 = done_count;
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
        checkOutput("full_busy_rise", 32'(busy), 32'd1);
        runUntilDone(10000, busy_low, timed_out);
        checkOutput("full_timeout", 32'(timed_out), 32'd0);
        checkOutput("full_done_busy_low", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("full_busy_gaps", 32'(busy_low), 32'd0);
        checkOutput("full_plots", 32'(plot_count - base), 32'd4320);
        checkOutput("full_done_count", 32'(done_count - dc0), 32'd1);
        checkOutput("full_colour_err", 32'(colour_err), 32'd0);
        checkOutput("cell0_first_x", 32'(px[base]), 32'd8);
        checkOutput("cell0_first_y", 32'(py[base]), 32'd16);
        checkOutput("cell0_row0_end_x", 32'(px[base + 11]), 32'd19);
        checkOutput("cell0_last_y", 32'(py[base + 71]), 32'd21);
        checkOutput("cell1_first_x", 32'(px[base + 72]), 32'd20);
        checkOutput("cell1_first_y", 32'(py[base + 72]), 32'd16);
        checkOutput("row1_first_x", 32'(px[base + 720]), 32'd8);
        checkOutput("row1_first_y", 32'(py[base + 720]), 32'd22);
        checkOutput("grid_last_x", 32'(px[base + 4319]), 32'd127);
        checkOutput("grid_last_y", 32'(py[base + 4319]), 32'd51);

        // Single cell (3,2) of type SBROWN
        $display("[TB] single cell redraw");
        mem[23] = SBROWN;
        base = plot_count; dc0 = done_count;
        applyStimulus(1'b0, 1'b1, 8'd3, 8'd2);
        for (int i = 0; i < 20 && !brickDrawEnable; i++) @(negedge clk);
        checkOutput("cell_draw_reached", 32'(brickDrawEnable), 32'd1);
        checkOutput("cell_addr", 32'(map_addr), 32'd23);
        checkOutput("cell_select", 32'(brickDrawSelect), 32'd4);
        checkOutput("cell_x", 32'(x), 32'd44);
        checkOutput("cell_y", 32'(y), 32'd28);
        runUntilDone(500, busy_low, timed_out);
        checkOutput("cell_timeout", 32'(timed_out), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("cell_plots", 32'(plot_count - base), 32'd72);
        checkOutput("cell_done_count", 32'(done_count - dc0), 32'd1);
        checkOutput("cell_first_x", 32'(px[base]), 32'd44);
        checkOutput("cell_first_y", 32'(py[base]), 32'd28);
        checkOutput("cell_last_x", 32'(px[base + 71]), 32'd55);
        checkOutput("cell_last_y", 32'(py[base + 71]), 32'd33);
        checkOutput("cell_colour_err", 32'(colour_err), 32'd0);

        // start and cell_req together, then a dropped cell_req mid-draw
        $display("[TB] start priority and dropped request");
        base = plot_count; dc0 = done_count;
        applyStimulus(1'b1, 1'b1, 8'd3, 8'd2);
        repeat (500) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
        runUntilDone(10000, busy_low, timed_out);
        checkOutput("prio_timeout", 32'(timed_out), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("prio_plots", 32'(plot_count - base), 32'd4320);
        checkOutput("prio_done_count", 32'(done_count - dc0), 32'd1);
        checkOutput("prio_busy_gaps", 32'(busy_low), 32'd0);

        // Reset in the middle of a draw
        $display("[TB] reset mid-draw");
        dc0 = done_count;
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
        repeat (100) @(negedge clk);
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_plot", 32'(vga_plot), 32'd0);
        checkOutput("abort_enable", 32'(brickDrawEnable), 32'd0);
        checkOutput("abort_addr", 32'(map_addr), 32'd0);
        checkOutput("abort_x", 32'(x), 32'd0);
        checkOutput("abort_vga_x", 32'(vga_x), 32'd0);
        checkOutput("abort_select", 32'(brickDrawSelect), 32'd0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("abort_no_done", 32'(done_count - dc0), 32'd0);
        base = plot_count;
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
        runUntilDone(10000, busy_low, timed_out);
        checkOutput("restart_timeout", 32'(timed_out), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("restart_plots", 32'(plot_count - base), 32'd4320);
        checkOutput("restart_done_count", 32'(done_count - dc0), 32'd1);

        // Out-of-range cell request is ignored
        $display("[TB] out-of-range request");
        pc0 = plot_count; cc0 = clear_count; busy_low = 0;
        applyStimulus(1'b0, 1'b1, 8'd10, 8'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busy_low++;
        end
        checkOutput("oor_busy_cycles", 32'(busy_low), 32'd0);
        checkOutput("oor_plots", 32'(plot_count - pc0), 32'd0);
        checkOutput("oor_clears", 32'(clear_count - cc0), 32'd0);
        checkOutput("oor_addr", 32'(map_addr), 32'(6'd59));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
